// File: rtl/uart_cmd_pkg.sv
// Shared opcode/response bytes and FSM state encoding for the UART command sequencer.
// Pure declarations: no latency, no flow control.
package uart_cmd_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_ADDR = 3'd1,
        ST_GET_DATA = 3'd2,
        ST_MEM_REQ  = 3'd3,
        ST_MEM_WAIT = 3'd4,
        ST_TX_SEND  = 3'd5,
        ST_TX_WAIT  = 3'd6
    } state_t;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear, o_expired combinational at the limit.
// Counter saturates at the limit; clear has priority over enable.
module uart_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 1_200_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_expired;

    assign w_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign o_expired = w_expired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !w_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Host command sequencer: UART bytes -> one SRAM access -> one reply byte; mem_req one cycle after last byte.
// Stalls on mem_ready, mem_rvalid and tx_ready; stray rx bytes while busy are dropped with cmd_err.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int ADDR_W         = 19,
    parameter int ADDR_BYTES     = 3,
    parameter int TIMEOUT_CYCLES = 1_200_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done_tick,
    input  logic [7:0]        r_data,
    input  logic              tx_ready,
    input  logic              tx_done_tick,
    output logic              tx_start,
    output logic [7:0]        w_data,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    localparam int SR_W  = 8 * ADDR_BYTES;
    localparam int CNT_W = $clog2(ADDR_BYTES + 1);

    state_t           r_state, w_state_nxt;
    logic [SR_W-1:0]  r_addr_sr, w_addr_nxt;
    logic [CNT_W-1:0] r_byte_cnt, w_cnt_nxt;
    logic             r_is_read, w_is_read_nxt;
    logic [7:0]       r_mem_wdata, w_wdata_nxt;
    logic [7:0]       r_tx_data, w_tx_nxt;
    logic             w_err;
    logic             w_tmr_clear;
    logic             w_tmr_en;
    logic             w_expired;

    uart_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_tmr_clear),
        .i_enable  (w_tmr_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr_sr   <= '0;
            r_byte_cnt  <= '0;
            r_is_read   <= 1'b0;
            r_mem_wdata <= '0;
            r_tx_data   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr_sr   <= w_addr_nxt;
            r_byte_cnt  <= w_cnt_nxt;
            r_is_read   <= w_is_read_nxt;
            r_mem_wdata <= w_wdata_nxt;
            r_tx_data   <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr_sr;
        w_cnt_nxt     = r_byte_cnt;
        w_is_read_nxt = r_is_read;
        w_wdata_nxt   = r_mem_wdata;
        w_tx_nxt      = r_tx_data;
        w_err         = 1'b0;
        w_tmr_clear   = 1'b1;
        w_tmr_en      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_done_tick) begin
                    if (r_data == OP_WRITE || r_data == OP_READ) begin
                        w_is_read_nxt = (r_data == OP_READ);
                        w_cnt_nxt     = '0;
                        w_state_nxt   = ST_GET_ADDR;
                    end else begin
                        w_tx_nxt    = RSP_ERR;
                        w_err       = 1'b1;
                        w_state_nxt = ST_TX_SEND;
                    end
                end
            end
            // Expiry is checked before the rx strobe so a coincident byte is dropped.
            ST_GET_ADDR: begin
                w_tmr_clear = 1'b0;
                w_tmr_en    = 1'b1;
                if (w_expired) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (rx_done_tick) begin
                    w_tmr_clear = 1'b1;
                    w_addr_nxt  = SR_W'({r_addr_sr, r_data});
                    w_cnt_nxt   = r_byte_cnt + 1'b1;
                    if (r_byte_cnt == CNT_W'(ADDR_BYTES - 1)) begin
                        w_state_nxt = r_is_read ? ST_MEM_REQ : ST_GET_DATA;
                    end
                end
            end
            ST_GET_DATA: begin
                w_tmr_clear = 1'b0;
                w_tmr_en    = 1'b1;
                if (w_expired) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (rx_done_tick) begin
                    w_tmr_clear = 1'b1;
                    w_wdata_nxt = r_data;
                    w_state_nxt = ST_MEM_REQ;
                end
            end
            ST_MEM_REQ: begin
                w_err = rx_done_tick;
                if (mem_ready) begin
                    if (r_is_read) begin
                        w_state_nxt = ST_MEM_WAIT;
                    end else begin
                        w_tx_nxt    = RSP_OK;
                        w_state_nxt = ST_TX_SEND;
                    end
                end
            end
            ST_MEM_WAIT: begin
                w_err = rx_done_tick;
                if (mem_rvalid) begin
                    w_tx_nxt    = mem_rdata;
                    w_state_nxt = ST_TX_SEND;
                end
            end
            ST_TX_SEND: begin
                w_err = rx_done_tick;
                if (tx_ready) begin
                    w_state_nxt = ST_TX_WAIT;
                end
            end
            ST_TX_WAIT: begin
                w_err = rx_done_tick;
                if (tx_done_tick) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign tx_start  = (r_state == ST_TX_SEND) && tx_ready;
    assign w_data    = r_tx_data;
    assign mem_req   = (r_state == ST_MEM_REQ);
    assign mem_rw    = r_is_read;
    assign mem_addr  = r_addr_sr[ADDR_W-1:0];
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != ST_IDLE);
    assign cmd_err   = w_err;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl with small SRAM and UART transmitter models.
`timescale 1ns/1ps
module tb_uart_cmd_ctrl;

    typedef struct {
        logic        rw;
        logic [18:0] addr;
        logic [7:0]  wdata;
    } mreq_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_done_tick = 1'b0;
    logic [7:0]  r_data = 8'h00;
    logic        tx_ready = 1'b1;
    logic        tx_done_tick = 1'b0;
    logic        tx_start;
    logic [7:0]  w_data;
    logic        mem_req;
    logic        mem_rw;
    logic [18:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        busy;
    logic        cmd_err;

    int checks = 0;
    int errors = 0;

    mreq_t      exp_mem_q[$];
    logic [7:0] exp_tx_q[$];
    int         exp_err_push = 0;
    int         err_seen = 0;
    int         tx_fire_cnt = 0;
    logic [7:0] last_tx = 8'h00;

    uart_cmd_ctrl #(
        .ADDR_W(19), .ADDR_BYTES(3), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .r_data(r_data),
        .tx_ready(tx_ready), .tx_done_tick(tx_done_tick), .tx_start(tx_start), .w_data(w_data),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_done_tick = 1'b1;
        r_data = b;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic push_mem(input logic rw, input logic [18:0] addr, input logic [7:0] wdata);
        mreq_t e;
        e.rw = rw; e.addr = addr; e.wdata = wdata;
        exp_mem_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, {63'd0, busy}, 64'd0);
        check({name, "_memq"}, 64'(exp_mem_q.size()), 64'd0);
        check({name, "_txq"}, 64'(exp_tx_q.size()), 64'd0);
        check({name, "_errs"}, 64'(err_seen), 64'(exp_err_push));
    endtask

    // SRAM model: ready two cycles after request, read data three cycles after accept.
    initial begin
        logic [7:0]  mem_arr [logic [18:0]];
        int          rdy_cnt, rv_cnt;
        logic        m_rw;
        logic [18:0] m_addr;
        logic [7:0]  m_wdata;
        rdy_cnt = 0; rv_cnt = 0; m_rw = 1'b0; m_addr = '0; m_wdata = '0;
        mem_arr[19'h00007] = 8'h3C;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                mem_ready = 1'b0; mem_rvalid = 1'b0; rdy_cnt = 0; rv_cnt = 0;
            end else begin
                mem_rvalid = 1'b0;
                if (rv_cnt > 0) begin
                    rv_cnt--;
                    if (rv_cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata = mem_arr.exists(m_addr) ? mem_arr[m_addr] : 8'h00;
                    end
                end
                if (mem_ready) begin
                    mem_ready = 1'b0;
                    if (m_rw) rv_cnt = 3;
                    else mem_arr[m_addr] = m_wdata;
                end else if (mem_req) begin
                    rdy_cnt++;
                    if (rdy_cnt == 2) begin
                        mem_ready = 1'b1; rdy_cnt = 0;
                        m_rw = mem_rw; m_addr = mem_addr; m_wdata = mem_wdata;
                    end
                end
            end
        end
    end

    // Transmitter model: busy for four cycles after each tx_start.
    initial begin
        int tx_cnt, tx_taken;
        tx_cnt = 0; tx_taken = 0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                tx_ready = 1'b1; tx_done_tick = 1'b0; tx_cnt = 0; tx_taken = tx_fire_cnt;
            end else begin
                tx_done_tick = 1'b0;
                if (tx_cnt > 0) begin
                    tx_cnt--;
                    if (tx_cnt == 0) begin
                        tx_done_tick = 1'b1; tx_ready = 1'b1;
                    end
                end
                if (tx_fire_cnt != tx_taken) begin
                    tx_taken = tx_fire_cnt; tx_ready = 1'b0; tx_cnt = 4;
                end
            end
        end
    end

    // Monitor: compares every DUT-presented output against the scoreboard queues.
    initial begin
        mreq_t      e;
        logic [7:0] t;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mem_req && mem_ready) begin
                    if (exp_mem_q.size() == 0) begin
                        check("mem_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = exp_mem_q.pop_front();
                        check("mem_rw", {63'd0, mem_rw}, {63'd0, e.rw});
                        check("mem_addr", 64'(mem_addr), 64'(e.addr));
                        if (!e.rw) check("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
                    end
                end
                if (tx_start) begin
                    tx_fire_cnt++;
                    last_tx = w_data;
                    if (exp_tx_q.size() == 0) begin
                        check("tx_unexpected", 64'(w_data), 64'h100);
                    end else begin
                        t = exp_tx_q.pop_front();
                        check("tx_byte", 64'(w_data), 64'(t));
                    end
                end
                if (tx_done_tick && busy) check("tx_stable", 64'(w_data), 64'(last_tx));
                if (cmd_err) begin
                    check("cmd_err_expected", 64'(err_seen < exp_err_push), 64'd1);
                    err_seen++;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        @(negedge clk);
        check("reset_outputs", {25'd0, tx_start, mem_req, cmd_err, busy, w_data, mem_addr, mem_wdata}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: write with latency check, then write whose upper address bits are discarded
        push_mem(1'b0, 19'h12345, 8'hA5);
        exp_tx_q.push_back(8'h4B);
        send_byte(8'h57); send_byte(8'h01); send_byte(8'h23); send_byte(8'h45); send_byte(8'hA5);
        @(negedge clk);
        check("t1_req_latency", {63'd0, mem_req}, 64'd1);
        wait_idle("t1");
        push_mem(1'b0, 19'h70010, 8'h5A);
        exp_tx_q.push_back(8'h4B);
        send_byte(8'h57); send_byte(8'hFF); send_byte(8'h00); send_byte(8'h10); send_byte(8'h5A);
        wait_idle("t1b");

        // 2: read back
        push_mem(1'b1, 19'h12345, 8'h00);
        exp_tx_q.push_back(8'hA5);
        send_byte(8'h52); send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
        wait_idle("t2");

        // 3: unknown opcode
        exp_tx_q.push_back(8'h3F);
        exp_err_push++;
        send_byte(8'h00);
        wait_idle("t3");

        // 4: timeout in address phase, then a normal read
        exp_err_push++;
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
        n = 0;
        for (int i = 1; i <= 150; i++) begin
            @(negedge clk);
            if (cmd_err) begin
                n = i;
                break;
            end
        end
        check("t4_timeout_cycle", 64'(n), 64'd101);
        @(negedge clk);
        check("t4_back_idle", {63'd0, busy}, 64'd0);
        push_mem(1'b1, 19'h00007, 8'h00);
        exp_tx_q.push_back(8'h3C);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
        wait_idle("t4");

        // 5: stray byte during MEM_WAIT
        push_mem(1'b1, 19'h12345, 8'h00);
        exp_tx_q.push_back(8'hA5);
        exp_err_push++;
        send_byte(8'h52); send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
        n = 0;
        while (!(mem_req && mem_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_accept_seen", {63'd0, mem_req && mem_ready}, 64'd1);
        send_byte(8'h11);
        wait_idle("t5");

        // 6: reset during TX_WAIT, then a normal write
        push_mem(1'b1, 19'h00007, 8'h00);
        exp_tx_q.push_back(8'h3C);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
        n = 0;
        while (!tx_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_tx_seen", {63'd0, tx_start}, 64'd1);
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("t6_reset_outputs", {25'd0, tx_start, mem_req, cmd_err, busy, w_data, mem_addr, mem_wdata}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        push_mem(1'b0, 19'h00055, 8'h77);
        exp_tx_q.push_back(8'h4B);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h55); send_byte(8'h77);
        wait_idle("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
